// File: rtl/vpu_linebuffer_mb_pkg.sv
// Shared constants and types for the VPU multi-bank line buffer.
package vpu_linebuffer_mb_pkg;
    localparam int LINEBUFF_BANKS  = 3;
    localparam int LINEBUFF_BANK_W = 2;
    localparam int LB_CLEAR_VAL    = 0;

    typedef enum logic {LB_IDLE, LB_CLEAR} lb_state_t;
endpackage

// File: rtl/vpu_linebuffer_mb_if.sv
// Line buffer bus: swap control, scanout read port A, compositor port B.
interface vpu_linebuffer_mb_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    import vpu_linebuffer_mb_pkg::*;

    logic                       swap;
    logic                       busy;
    logic                       overrun;
    logic                       a_en;
    logic [ADDR_W-1:0]          a_addr;
    logic [DATA_W-1:0]          a_dout;
    logic                       b_en;
    logic                       b_we;
    logic [ADDR_W-1:0]          b_addr;
    logic [DATA_W-1:0]          b_din;
    logic [DATA_W-1:0]          b_dout;
    logic                       b_ready;
    logic [LINEBUFF_BANK_W-1:0] wr_bank;
    logic [LINEBUFF_BANK_W-1:0] rd_bank;

    modport master (
        output swap, a_en, a_addr, b_en, b_we, b_addr, b_din,
        input  busy, overrun, a_dout, b_dout, b_ready, wr_bank, rd_bank
    );
    modport slave (
        input  swap, a_en, a_addr, b_en, b_we, b_addr, b_din,
        output busy, overrun, a_dout, b_dout, b_ready, wr_bank, rd_bank
    );
endinterface

// File: rtl/vpu_linebuffer_mb_bram.sv
// True dual-port block RAM, registered outputs, read-first on port B; port A is read-only.
module vpu_linebuffer_mb_bram #(
    parameter int DEPTH  = 320,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              a_en,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [DATA_W-1:0] a_dout,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    output logic [DATA_W-1:0] b_dout
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (a_en) a_dout <= mem[a_addr];
    end

    always_ff @(posedge clk) begin
        if (b_en) begin
            b_dout <= mem[b_addr];
            if (b_we) mem[b_addr] <= b_din;
        end
    end
endmodule

// File: rtl/vpu_linebuffer_mb.sv
// N-bank rotating line buffer: compositor writes the write bank, scanout reads the previous one,
// and each swap clears the new write bank through port B.
module vpu_linebuffer_mb
    import vpu_linebuffer_mb_pkg::*;
#(
    parameter int              BANKS     = LINEBUFF_BANKS,
    parameter int              DEPTH     = 320,
    parameter int              ADDR_W    = 9,
    parameter int              DATA_W    = 16,
    parameter logic [DATA_W-1:0] CLEAR_VAL = DATA_W'(LB_CLEAR_VAL),
    parameter bit              TRANSP_EN = 1'b1
) (
    input logic              clk,
    input logic              rst,
    vpu_linebuffer_mb_if.slave lb
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [LINEBUFF_BANK_W-1:0] TOP_BANK = LINEBUFF_BANK_W'(BANKS - 1);

    lb_state_t                  state, state_nx;
    logic [ADDR_W-1:0]          clr_cnt, cnt_nx;
    logic [LINEBUFF_BANK_W-1:0] wr_bank, wr_nx, rd_bank;
    logic                       overrun, ovr_nx, busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LB_CLEAR;
            clr_cnt <= '0;
            wr_bank <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nx;
            clr_cnt <= cnt_nx;
            wr_bank <= wr_nx;
            overrun <= ovr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = clr_cnt;
        wr_nx    = wr_bank;
        ovr_nx   = overrun;
        case (state)
            LB_IDLE: if (lb.swap) begin
                state_nx = LB_CLEAR;
                cnt_nx   = '0;
                wr_nx    = (wr_bank == TOP_BANK) ? '0 : wr_bank + 1'b1;
            end
            LB_CLEAR: begin
                if (lb.swap) ovr_nx = 1'b1;
                if (clr_cnt == LAST) state_nx = LB_IDLE;
                else                 cnt_nx   = clr_cnt + 1'b1;
            end
            default: state_nx = LB_IDLE;
        endcase
    end

    assign busy    = (state == LB_CLEAR);
    assign rd_bank = (wr_bank == '0) ? TOP_BANK : wr_bank - 1'b1;

    // Port B is shared: the clear sequencer owns it while busy, the compositor otherwise.
    logic              a_in, b_in, b_acc;
    logic              pb_en, pb_we;
    logic [ADDR_W-1:0] pb_addr;
    logic [DATA_W-1:0] pb_din;

    assign a_in    = {1'b0, lb.a_addr} < DEPTH_L;
    assign b_in    = {1'b0, lb.b_addr} < DEPTH_L;
    assign b_acc   = lb.b_en & ~busy;
    assign pb_en   = busy | (b_acc & b_in);
    assign pb_we   = busy | (lb.b_we & b_in & (~TRANSP_EN | lb.b_din[DATA_W-1]));
    assign pb_addr = busy ? clr_cnt : lb.b_addr;
    assign pb_din  = busy ? CLEAR_VAL : lb.b_din;

    logic [DATA_W-1:0] bank_a_q [BANKS];
    logic [DATA_W-1:0] bank_b_q [BANKS];

    for (genvar i = 0; i < BANKS; i++) begin : g_bank
        vpu_linebuffer_mb_bram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bram (
            .clk    (clk),
            .a_en   (lb.a_en & a_in & (rd_bank == LINEBUFF_BANK_W'(i))),
            .a_addr (lb.a_addr),
            .a_dout (bank_a_q[i]),
            .b_en   (pb_en & (wr_bank == LINEBUFF_BANK_W'(i))),
            .b_we   (pb_we),
            .b_addr (pb_addr),
            .b_din  (pb_din),
            .b_dout (bank_b_q[i])
        );
    end

    // Outputs are live from the RAM only in the cycle after an access, then held locally,
    // so RAM traffic from clears or later rotations never disturbs the visible data.
    logic                       a_cap, a_oor, b_cap, b_oor;
    logic [LINEBUFF_BANK_W-1:0] a_sel, b_sel;
    logic [DATA_W-1:0]          a_hold, b_hold, a_q, b_q, a_live, b_live;

    always_comb begin
        a_q = '0;
        b_q = '0;
        for (int unsigned i = 0; i < BANKS; i++) begin
            if (a_sel == LINEBUFF_BANK_W'(i)) a_q = bank_a_q[i];
            if (b_sel == LINEBUFF_BANK_W'(i)) b_q = bank_b_q[i];
        end
    end

    assign a_live = a_oor ? CLEAR_VAL : a_q;
    assign b_live = b_oor ? CLEAR_VAL : b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_cap  <= 1'b0;
            b_cap  <= 1'b0;
            a_oor  <= 1'b0;
            b_oor  <= 1'b0;
            a_sel  <= '0;
            b_sel  <= '0;
            a_hold <= '0;
            b_hold <= '0;
        end else begin
            a_cap <= lb.a_en;
            b_cap <= b_acc;
            if (lb.a_en) begin
                a_sel <= rd_bank;
                a_oor <= ~a_in;
            end
            if (b_acc) begin
                b_sel <= wr_bank;
                b_oor <= ~b_in;
            end
            if (a_cap) a_hold <= a_live;
            if (b_cap) b_hold <= b_live;
        end
    end

    assign lb.a_dout  = a_cap ? a_live : a_hold;
    assign lb.b_dout  = b_cap ? b_live : b_hold;
    assign lb.busy    = busy;
    assign lb.b_ready = ~busy;
    assign lb.overrun = overrun;
    assign lb.wr_bank = wr_bank;
    assign lb.rd_bank = rd_bank;
endmodule

// File: tb/tb_vpu_linebuffer_mb.sv
// Directed bench for vpu_linebuffer_mb (BANKS=3, DEPTH=320, DATA_W=16, CLEAR_VAL=0).
module tb_vpu_linebuffer_mb;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    vpu_linebuffer_mb_if #(.ADDR_W(9), .DATA_W(16)) lb ();

    vpu_linebuffer_mb #(
        .BANKS(3), .DEPTH(320), .ADDR_W(9), .DATA_W(16), .CLEAR_VAL(16'h0000), .TRANSP_EN(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .lb  (lb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        lb.swap = 1'b0; lb.a_en = 1'b0; lb.b_en = 1'b0; lb.b_we = 1'b0;
    endtask

    task automatic b_write(input logic [8:0] addr, input logic [15:0] data);
        lb.b_en = 1'b1; lb.b_we = 1'b1; lb.b_addr = addr; lb.b_din = data;
        tick();
        idle_bus();
    endtask

    task automatic b_read(input logic [8:0] addr);
        lb.b_en = 1'b1; lb.b_we = 1'b0; lb.b_addr = addr;
        tick();
        idle_bus();
    endtask

    task automatic a_read(input logic [8:0] addr);
        lb.a_en = 1'b1; lb.a_addr = addr;
        tick();
        idle_bus();
    endtask

    // Counts cycles with busy high, starting at the current sample.
    task automatic count_busy(output int n);
        n = 0;
        while (lb.busy === 1'b1 && n < 2000) begin
            n++;
            tick();
        end
        if (n >= 2000) chk("busy_timeout", 32'(n), 32'd320);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        idle_bus();
        lb.a_addr = '0; lb.b_addr = '0; lb.b_din = '0;
        tick();
        rst = 1'b0;

        chk("rst_busy",    32'(lb.busy),    32'd1);
        chk("rst_ready",   32'(lb.b_ready), 32'd0);
        chk("rst_wr_bank", 32'(lb.wr_bank), 32'd0);
        chk("rst_rd_bank", 32'(lb.rd_bank), 32'd2);
        chk("rst_overrun", 32'(lb.overrun), 32'd0);
        chk("rst_a_dout",  32'(lb.a_dout),  32'h0);
        chk("rst_b_dout",  32'(lb.b_dout),  32'h0);
        count_busy(n);
        chk("rst_busy_len", 32'(n), 32'd320);
        chk("idle_ready",  32'(lb.b_ready), 32'd1);

        // Bank 0: transparency, read-first, range checks
        b_write(9'd5, 16'h8123);
        b_write(9'd7, 16'h0123);
        b_read(9'd7);
        chk("transp_drop", 32'(lb.b_dout), 32'h0000);
        b_write(9'd7, 16'h8123);
        b_read(9'd7);
        chk("opaque_store", 32'(lb.b_dout), 32'h8123);
        b_write(9'd7, 16'h8999);
        chk("read_first", 32'(lb.b_dout), 32'h8123);
        b_write(9'd319, 16'h8555);
        b_write(9'd320, 16'hFFFF);
        b_read(9'd320);
        chk("b_oor_read", 32'(lb.b_dout), 32'h0000);
        b_read(9'd319);
        chk("b_last_addr", 32'(lb.b_dout), 32'h8555);
        tick();
        chk("b_hold", 32'(lb.b_dout), 32'h8555);

        // Swap 1: bank 0 becomes display
        lb.swap = 1'b1;
        tick();
        idle_bus();
        chk("sw1_wr_bank", 32'(lb.wr_bank), 32'd1);
        chk("sw1_rd_bank", 32'(lb.rd_bank), 32'd0);
        chk("sw1_busy",    32'(lb.busy),    32'd1);
        repeat (5) tick();
        b_write(9'd2, 16'h8777);
        chk("busy_b_hold", 32'(lb.b_dout), 32'h8555);
        count_busy(n);
        a_read(9'd5);
        chk("a_addr5", 32'(lb.a_dout), 32'h8123);
        a_read(9'd7);
        chk("a_addr7", 32'(lb.a_dout), 32'h8999);
        a_read(9'd320);
        chk("a_oor_read", 32'(lb.a_dout), 32'h0000);
        a_read(9'd319);
        chk("a_last_addr", 32'(lb.a_dout), 32'h8555);
        tick();
        chk("a_hold", 32'(lb.a_dout), 32'h8555);
        b_read(9'd2);
        chk("busy_write_dropped", 32'(lb.b_dout), 32'h0000);
        b_read(9'd5);
        chk("bank1_cleared", 32'(lb.b_dout), 32'h0000);
        b_write(9'd5, 16'h8ABC);

        // Swap 2 with a second swap 10 cycles later
        lb.swap = 1'b1;
        tick();
        idle_bus();
        n = 0;
        repeat (10) begin
            if (lb.busy === 1'b1) n++;
            tick();
        end
        lb.swap = 1'b1;
        if (lb.busy === 1'b1) n++;
        tick();
        idle_bus();
        chk("ovr_flag",    32'(lb.overrun), 32'd1);
        chk("ovr_wr_bank", 32'(lb.wr_bank), 32'd2);
        begin
            int rest;
            count_busy(rest);
            n += rest;
        end
        chk("ovr_busy_len", 32'(n), 32'd320);
        chk("sw2_rd_bank", 32'(lb.rd_bank), 32'd1);

        // Swap 3 with a scanout read in the same cycle: old display bank (1) answers
        lb.swap = 1'b1; lb.a_en = 1'b1; lb.a_addr = 9'd5;
        tick();
        idle_bus();
        chk("swap_cycle_read", 32'(lb.a_dout), 32'h8ABC);
        chk("sw3_wr_bank", 32'(lb.wr_bank), 32'd0);
        chk("sw3_rd_bank", 32'(lb.rd_bank), 32'd2);
        a_read(9'd5);
        chk("bank2_display", 32'(lb.a_dout), 32'h0000);
        count_busy(n);
        chk("sw3_busy_len", 32'(n), 32'd319);
        b_read(9'd5);
        chk("bank0_recleared", 32'(lb.b_dout), 32'h0000);
        chk("ovr_sticky", 32'(lb.overrun), 32'd1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_overrun", 32'(lb.overrun), 32'd0);
        chk("rst2_wr_bank", 32'(lb.wr_bank), 32'd0);
        chk("rst2_busy",    32'(lb.busy),    32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
